// File: rtl/wam_mole_gen.sv
// Whack-a-mole target generator and hit judge: pops one mole at a time in a
// pseudo-random hole, times its life and judges button presses against it.
module wam_mole_gen #(
  parameter int          N_HOLES   = 8,
  parameter int          UP_CYC    = 50000000,
  parameter int          GAP_CYC   = 25000000,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               en,
  input  logic [N_HOLES-1:0] btn,
  output logic [N_HOLES-1:0] mole,
  output logic [N_HOLES-1:0] hit,
  output logic               miss,
  output logic [1:0]         state_dbg
);

  localparam int IW = $clog2(N_HOLES);
  localparam int CW = $clog2(UP_CYC > GAP_CYC ? UP_CYC : GAP_CYC);
  localparam logic [CW-1:0] UP_LD  = CW'(UP_CYC - 1);
  localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPAWN = 2'd1,
    UP    = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t             state;
  logic [15:0]        lfsr;
  logic [N_HOLES-1:0] btn_q;
  logic [N_HOLES-1:0] rise;
  logic [IW-1:0]      last;
  logic [IW-1:0]      pick;
  logic [CW-1:0]      cnt;

  assign state_dbg = state;
  assign rise      = btn & ~btn_q;

  // Never pop the same hole twice in a row: bump a repeat to the next hole.
  always_comb begin
    pick = lfsr[IW-1:0];
    if (pick == last) pick = pick + IW'(1);
  end

  // Galois LFSR, x^16+x^14+x^13+x^11; frozen while the game is stopped.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      lfsr  <= LFSR_SEED;
      btn_q <= '0;
    end else begin
      btn_q <= btn;
      if (en) lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
      mole  <= '0;
      hit   <= '0;
      miss  <= 1'b0;
      last  <= '0;
      cnt   <= '0;
    end else begin
      hit  <= '0;
      miss <= 1'b0;
      if (!en) begin
        state <= IDLE;
        mole  <= '0;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: state <= SPAWN;
          SPAWN: begin
            last  <= pick;
            mole  <= {{(N_HOLES-1){1'b0}}, 1'b1} << pick;
            cnt   <= UP_LD;
            state <= UP;
          end
          UP: begin
            // A whack in the final cycle still wins over the timeout.
            if (rise[last]) begin
              hit   <= mole;
              mole  <= '0;
              cnt   <= GAP_LD;
              state <= GAP;
            end else if (cnt == '0) begin
              miss  <= 1'b1;
              mole  <= '0;
              cnt   <= GAP_LD;
              state <= GAP;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          GAP: begin
            if (cnt == '0) state <= SPAWN;
            else           cnt   <= cnt - CW'(1);
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wam_mole_gen.sv
// Self-checking bench for wam_mole_gen: each mole lifetime ends in an outcome
// ({hit,miss}) and a length that the driver predicts and the monitor verifies.
module tb_wam_mole_gen;

  localparam int N = 8;
  localparam logic [15:0] SEED = 16'hACE1;

  logic         clk = 1'b0;
  logic         clr;
  logic         en;
  logic [N-1:0] btn;
  logic [N-1:0] mole;
  logic [N-1:0] hit;
  logic         miss;
  logic [1:0]   state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] exp_q[$];
  int         exp_life_q[$];

  wam_mole_gen #(.N_HOLES(N), .UP_CYC(8), .GAP_CYC(4), .LFSR_SEED(SEED)) dut (
    .clk(clk), .clr(clr), .en(en), .btn(btn),
    .mole(mole), .hit(hit), .miss(miss), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference LFSR ----------------
  logic [15:0] m_lfsr, m_prev;
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    logic [15:0] n;
    n     = l >> 1;
    n[15] = l[0];
    n[13] = l[14] ^ l[0];
    n[12] = l[13] ^ l[0];
    n[10] = l[11] ^ l[0];
    return n;
  endfunction

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      m_lfsr <= SEED;
      m_prev <= SEED;
    end else begin
      m_prev <= m_lfsr;
      if (en) m_lfsr <= lfsr_next(m_lfsr);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [N-1:0] prev_mole;
  logic [2:0]   m_last;
  logic [2:0]   eidx;
  logic [7:0]   e_oh;
  logic [8:0]   e_out;
  int           life, gap, e_life;
  bit           gap_valid;

  always @(posedge clk) begin
    #1;
    if (!clr) begin
      prev_mole = '0; life = 0; gap = 0; gap_valid = 0; m_last = '0;
    end else begin
      if (mole != 0 && prev_mole == 0) begin
        eidx = m_prev[2:0];
        if (eidx == m_last) eidx = eidx + 3'd1;
        e_oh = 8'd1 << eidx;
        check("mole_idx", 32'(mole), 32'(e_oh));
        if (gap_valid) check("gap_len", 32'(gap), 32'd5);
        m_last = eidx;
        life   = 1;
        if (hit != 0 || miss) check("stray_pulse", 32'({hit, miss}), 32'd0);
      end else if (mole != 0) begin
        life++;
        if (hit != 0 || miss) check("stray_pulse", 32'({hit, miss}), 32'd0);
      end else if (prev_mole != 0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_fall", 32'd1, 32'd0);
          gap_valid = 0;
        end else begin
          e_out  = exp_q.pop_front();
          e_life = exp_life_q.pop_front();
          check("outcome", 32'({hit, miss}), 32'(e_out));
          check("life_len", 32'(life), 32'(e_life));
          gap_valid = (e_out != 0);
        end
        gap = 1;
      end else begin
        gap++;
        if (hit != 0 || miss) check("stray_pulse", 32'({hit, miss}), 32'd0);
      end
      prev_mole = mole;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_mole(output int idx, output int n);
    n = 0; idx = 0;
    while (mole == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (mole == 0) check("wait_mole_timeout", 32'd0, 32'd1);
    for (int i = 0; i < N; i++) if (mole[i]) idx = i;
  endtask

  task automatic wait_fall();
    int n = 0;
    while (mole != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (mole != 0) check("wait_fall_timeout", 32'd0, 32'd1);
  endtask

  task automatic expect_end(input logic [8:0] outcome, input int len);
    exp_q.push_back(outcome);
    exp_life_q.push_back(len);
  endtask

  // ---------------- stimulus ----------------
  int idx, idx1, n, w;

  initial begin
    clr = 1'b0; en = 1'b1; btn = '0;
    repeat (3) @(negedge clk);
    check("rst_mole", 32'(mole), 32'd0);
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_miss", 32'(miss), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    clr = 1'b1;
    @(negedge clk);
    check("spawn_state", 32'(state_dbg), 32'd1);
    check("spawn_mole", 32'(mole), 32'd0);

    // timeout, then a fresh mole in another hole
    wait_mole(idx1, n);
    check("first_mole_lat", 32'(n), 32'd1);
    expect_end(9'h001, 8);
    wait_fall();
    wait_mole(idx, n);
    check("new_hole_diff", 32'(idx != idx1), 32'd1);

    // correct whack three cycles in
    expect_end({8'd1 << idx, 1'b0}, 4);
    repeat (3) @(negedge clk);
    btn[idx] = 1'b1;
    @(negedge clk);
    btn = '0;
    wait_fall();

    // every button held before the mole appears: no rise, so a miss
    btn = '1;
    wait_mole(idx, n);
    expect_end(9'h001, 8);
    wait_fall();
    btn = '0;

    // wrong-hole presses are ignored
    wait_mole(idx, n);
    expect_end(9'h001, 8);
    w = (idx + 5) % N;
    repeat (3) begin
      @(negedge clk); btn[w] = 1'b1;
      @(negedge clk); btn = '0;
    end
    wait_fall();

    // whack lands in the final up cycle
    wait_mole(idx, n);
    expect_end({8'd1 << idx, 1'b0}, 8);
    repeat (7) @(negedge clk);
    btn[idx] = 1'b1;
    @(negedge clk);
    btn = '0;
    wait_fall();

    // all buttons rise together: only the mole's hole pulses
    wait_mole(idx, n);
    expect_end({8'd1 << idx, 1'b0}, 3);
    repeat (2) @(negedge clk);
    btn = '1;
    @(negedge clk);
    btn = '0;
    wait_fall();

    // random-length timed whacks
    repeat (4) begin
      wait_mole(idx, n);
      w = $urandom_range(0, 7);
      expect_end({8'd1 << idx, 1'b0}, w + 1);
      repeat (w) @(negedge clk);
      btn[idx] = 1'b1;
      @(negedge clk);
      btn = '0;
      wait_fall();
    end

    // en dropped mid-up: mole clears, no pulse, quick restart
    wait_mole(idx, n);
    expect_end(9'h000, 4);
    repeat (3) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("abort_mole", 32'(mole), 32'd0);
    en = 1'b1;
    wait_mole(idx, n);
    check("reen_lat", 32'(n), 32'd2);

    // asynchronous reset mid-up
    repeat (2) @(negedge clk);
    #2 clr = 1'b0;
    #1;
    check("async_mole", 32'(mole), 32'd0);
    check("async_pulse", 32'({hit, miss}), 32'd0);
    repeat (2) @(negedge clk);
    clr = 1'b1;
    wait_mole(idx, n);
    check("post_rst_lat", 32'(n), 32'd2);
    expect_end(9'h001, 8);
    wait_fall();

    repeat (8) @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
